// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read side.
package regfile_pkg;
  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = $clog2(N);

  typedef logic [W-1:0]  reg_t;
  typedef logic [AW-1:0] ridx_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} rd_state_t;
endpackage

// File: rtl/rf_read_mux.sv
// Combinational index->value select: register 0 and out-of-range indices read 0.
// REGFILE_READ_BYPASS_EN: a same-cycle write-back to the selected index overrides the stale slice.
module rf_read_mux
  import regfile_pkg::*;
(
  input  logic [N*W-1:0] regs_flat,
  input  ridx_t          idx,
  input  logic           wb_en,
  input  ridx_t          wb_addr,
  input  reg_t           wb_data,
  output reg_t           val
);

  always_comb begin
    val = '0;
    // Loop starts at 1 so index 0 and any index >= N fall through to zero.
    for (int i = 1; i < N; i++) begin
      if (idx == ridx_t'(i)) val = regs_flat[i*W +: W];
    end
`ifdef REGFILE_READ_BYPASS_EN
    if (wb_en && (wb_addr == idx) && (idx != '0)) val = wb_data;
`endif
  end

  // Register 0's slice is never read; without forwarding the write-back port is unused too.
  logic unused_bits;
`ifdef REGFILE_READ_BYPASS_EN
  assign unused_bits = ^regs_flat[W-1:0];
`else
  assign unused_bits = ^{regs_flat[W-1:0], wb_en, wb_addr, wb_data};
`endif

endmodule

// File: rtl/regfile_read_stage.sv
// Two-source register read with a 2-entry skid buffer; pair visible the cycle after accept.
// Optional same-cycle write-back forwarding under REGFILE_READ_BYPASS_EN.
module regfile_read_stage
  import regfile_pkg::*;
(
  input  logic           Clk,
  input  logic           Clrn,
  input  logic           req_valid,
  output logic           req_ready,
  input  ridx_t          req_rs,
  input  ridx_t          req_rt,
  input  logic [N*W-1:0] regs_flat,
  input  logic           wb_en,
  input  ridx_t          wb_addr,
  input  reg_t           wb_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output reg_t           rsp_a,
  output reg_t           rsp_b
);

  rd_state_t state;
  reg_t      head_a, head_b, tail_a, tail_b;
  reg_t      new_a, new_b;
  logic      accept, pop;

  rf_read_mux u_mux_rs (
    .regs_flat (regs_flat),
    .idx       (req_rs),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .val       (new_a)
  );

  rf_read_mux u_mux_rt (
    .regs_flat (regs_flat),
    .idx       (req_rt),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .val       (new_b)
  );

  assign req_ready = Clrn && (state != TWO);
  assign rsp_valid = (state != EMPTY);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_a     = head_a;
  assign rsp_b     = head_b;

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state  <= EMPTY;
      head_a <= '0;
      head_b <= '0;
      tail_a <= '0;
      tail_b <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_a <= new_a;
            head_b <= new_b;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_a <= new_a;
            head_b <= new_b;
          end else if (accept) begin
            tail_a <= new_a;
            tail_b <= new_b;
            state  <= TWO;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        TWO: begin
          // Full: no accept is possible, so the tail simply moves up on a pop.
          if (pop) begin
            head_a <= tail_a;
            head_b <= tail_b;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
